// File: rtl/serial_addsub_unit.sv
// Digit-serial adder/subtractor: processes DIGIT bits per clock, LSB first,
// and presents the full result with carry/borrow and signed overflow on done.
module serial_addsub_unit #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow
);

  localparam int C     = WIDTH / DIGIT;
  localparam int CNT_W = $clog2(C + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(C - 1);

  generate
    if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
      $error("serial_addsub_unit: WIDTH must be >= 2 and a multiple of DIGIT");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Returns {signed overflow, carry out, DIGIT sum bits}; the carry into the
  // MSB is recovered from the MSB sum bit and the two MSB operand bits.
  function automatic logic [DIGIT+1:0] digit_add(input logic [DIGIT-1:0] x,
                                                 input logic [DIGIT-1:0] y,
                                                 input logic             cin);
    logic [DIGIT:0] s;
    logic           c_msb;
    s     = {1'b0, x} + {1'b0, y} + {{DIGIT{1'b0}}, cin};
    c_msb = s[DIGIT-1] ^ x[DIGIT-1] ^ y[DIGIT-1];
    return {c_msb ^ s[DIGIT], s};
  endfunction

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] rs_q, rs_d;
  logic             cy_q, cy_d;
  logic             md_q, md_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [DIGIT+1:0] add_w;
  logic [WIDTH-1:0] rs_next;

  assign add_w   = digit_add(sa_q[DIGIT-1:0], sb_q[DIGIT-1:0], cy_q);
  assign rs_next = (rs_q >> DIGIT) | (WIDTH'(add_w[DIGIT-1:0]) << (WIDTH - DIGIT));

  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    rs_d    = rs_q;
    cy_d    = cy_q;
    md_d    = md_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          sa_d    = a;
          sb_d    = mode ? ~b : b;
          cy_d    = mode;
          md_d    = mode;
          cnt_d   = '0;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        sa_d  = sa_q >> DIGIT;
        sb_d  = sb_q >> DIGIT;
        rs_d  = rs_next;
        cy_d  = add_w[DIGIT];
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) begin
          // subtraction reports borrow, i.e. the inverted final carry
          res_d   = rs_next;
          cout_d  = add_w[DIGIT] ^ md_q;
          ovf_d   = add_w[DIGIT+1];
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      rs_q    <= '0;
      cy_q    <= 1'b0;
      md_q    <= 1'b0;
      cnt_q   <= '0;
      res_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      rs_q    <= rs_d;
      cy_q    <= cy_d;
      md_q    <= md_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy      = (state_q == SHIFT);
  assign done      = (state_q == DONE);
  assign result    = res_q;
  assign carry_out = cout_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_serial_addsub_unit.sv
// Scoreboard bench for serial_addsub_unit: two 8-bit instances (DIGIT=1 and
// DIGIT=4), directed corner vectors plus randomized back-to-back traffic.
module tb_serial_addsub_unit;

  typedef struct {
    logic [7:0] r;
    logic       c;
    logic       v;
    int         cyc;
  } exp_t;

  logic       clk;
  logic       rst [2];
  logic       st  [2];
  logic       md  [2];
  logic [7:0] av  [2];
  logic [7:0] bv  [2];
  logic       bz  [2];
  logic       dn  [2];
  logic [7:0] rs  [2];
  logic       co  [2];
  logic       ov  [2];

  exp_t q0[$];
  exp_t q1[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  logic       rprev [2] = '{1'b0, 1'b0};
  logic       armed [2] = '{1'b0, 1'b0};
  logic [7:0] hr    [2] = '{8'h00, 8'h00};
  logic       hc    [2] = '{1'b0, 1'b0};
  logic       hv    [2] = '{1'b0, 1'b0};
  int         run   [2] = '{0, 0};

  serial_addsub_unit #(.WIDTH(8), .DIGIT(1)) u_d1 (
    .clk(clk), .reset(rst[0]), .start(st[0]), .mode(md[0]), .a(av[0]), .b(bv[0]),
    .busy(bz[0]), .done(dn[0]), .result(rs[0]), .carry_out(co[0]), .overflow(ov[0])
  );

  serial_addsub_unit #(.WIDTH(8), .DIGIT(4)) u_d4 (
    .clk(clk), .reset(rst[1]), .start(st[1]), .mode(md[1]), .a(av[1]), .b(bv[1]),
    .busy(bz[1]), .done(dn[1]), .result(rs[1]), .carry_out(co[1]), .overflow(ov[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int digits_of(int u);
    return (u == 0) ? 8 : 2;
  endfunction

  // Reference: plain integer arithmetic, overflow from the signed range.
  function automatic logic [9:0] ref_op(logic m, logic [7:0] x, logic [7:0] y);
    int   ux = int'(x);
    int   uy = int'(y);
    int   sx = int'($signed(x));
    int   sy = int'($signed(y));
    int   ures;
    int   sres;
    logic c;
    logic v;
    if (m) begin
      ures = ux - uy;
      sres = sx - sy;
      c    = (ux < uy);
    end else begin
      ures = ux + uy;
      sres = sx + sy;
      c    = (ures > 255);
    end
    v = (sres > 127) || (sres < -128);
    return {v, c, 8'(ures)};
  endfunction

  task automatic check(string name, int u, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s unit%0d cycle %0d: got %0h expected %0h", name, u, cyc, act, req);
    end
  endtask

  task automatic mon(int u);
    exp_t e;
    int   n;
    n = (u == 0) ? q0.size() : q1.size();
    if (rprev[u]) begin
      check("reset_state", u, 32'({bz[u], dn[u], rs[u], co[u], ov[u]}), 32'h0);
      hr[u]    = 8'h00;
      hc[u]    = 1'b0;
      hv[u]    = 1'b0;
      run[u]   = 0;
      armed[u] = 1'b1;
    end else if (armed[u]) begin
      check("busy_done_excl", u, 32'(bz[u] & dn[u]), 32'h0);
      if (dn[u]) begin
        if (n == 0) begin
          check("unexpected_done", u, 32'(dn[u]), 32'h0);
        end else begin
          e = (u == 0) ? q0.pop_front() : q1.pop_front();
          check("latency", u, 32'(cyc), 32'(e.cyc));
          check("result", u, 32'(rs[u]), 32'(e.r));
          check("carry_out", u, 32'(co[u]), 32'(e.c));
          check("overflow", u, 32'(ov[u]), 32'(e.v));
          hr[u] = e.r;
          hc[u] = e.c;
          hv[u] = e.v;
        end
      end else begin
        check("hold_outputs", u, 32'({rs[u], co[u], ov[u]}), 32'({hr[u], hc[u], hv[u]}));
        if (n > 0) begin
          e = (u == 0) ? q0[0] : q1[0];
          if (e.cyc < cyc) begin
            check("done_missing", u, 32'(dn[u]), 32'h1);
            if (u == 0) void'(q0.pop_front());
            else        void'(q1.pop_front());
          end
        end
      end
      if (bz[u]) begin
        run[u]++;
      end else if (run[u] != 0) begin
        check("busy_length", u, 32'(run[u]), 32'(digits_of(u)));
        run[u] = 0;
      end
    end
    rprev[u] = rst[u];
  endtask

  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) mon(u);
  end

  task automatic run_op(int u, logic m, logic [7:0] x, logic [7:0] y, bit hold);
    exp_t       e;
    logic [9:0] rr;
    int         cc;
    cc    = digits_of(u);
    rr    = ref_op(m, x, y);
    e.r   = rr[7:0];
    e.c   = rr[8];
    e.v   = rr[9];
    e.cyc = cyc + 1 + cc;
    st[u] = 1'b1;
    md[u] = m;
    av[u] = x;
    bv[u] = y;
    if (u == 0) q0.push_back(e);
    else        q1.push_back(e);
    @(posedge clk); #1;
    for (int i = 0; i < cc; i++) begin
      md[u] = 1'($urandom);
      av[u] = 8'($urandom);
      bv[u] = 8'($urandom);
      st[u] = hold ? 1'b1 : 1'($urandom);
      @(posedge clk); #1;
    end
    if (!hold) begin
      st[u] = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int u = 0; u < 2; u++) begin
      rst[u] = 1'b1;
      st[u]  = 1'b0;
      md[u]  = 1'b0;
      av[u]  = 8'h00;
      bv[u]  = 8'h00;
    end
    repeat (3) @(posedge clk);
    #1;
    rst[0] = 1'b0;
    rst[1] = 1'b0;

    run_op(0, 1'b0, 8'hEB, 8'hFB, 1'b0);
    run_op(0, 1'b0, 8'h7F, 8'h01, 1'b0);
    run_op(0, 1'b1, 8'h20, 8'h30, 1'b0);
    run_op(0, 1'b1, 8'h80, 8'h01, 1'b0);

    // abort: reset lands on the third SHIFT edge, no done may follow
    st[0] = 1'b1; md[0] = 1'b0; av[0] = 8'hFF; bv[0] = 8'h01;
    @(posedge clk); #1;
    st[0] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst[0] = 1'b1;
    @(posedge clk); #1;
    rst[0] = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
    end

    for (int i = 0; i < 20; i++)
      run_op(0, 1'($urandom), 8'($urandom), 8'($urandom), i != 19);
    for (int i = 0; i < 20; i++) begin
      run_op(0, 1'($urandom), 8'($urandom), 8'($urandom), 1'b0);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end

    run_op(1, 1'b0, 8'h7E, 8'hF0, 1'b0);
    run_op(1, 1'b1, 8'h00, 8'h01, 1'b0);
    for (int i = 0; i < 15; i++)
      run_op(1, 1'($urandom), 8'($urandom), 8'($urandom), i != 14);
    for (int i = 0; i < 15; i++) begin
      run_op(1, 1'($urandom), 8'($urandom), 8'($urandom), 1'b0);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end

    repeat (30) begin
      @(posedge clk); #1;
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
